// File: rtl/ss_scroll_ctrl.sv
// Message sequencer for a four-digit seven-segment driver: static display of short
// messages, right-to-left scrolling (once or looped) of longer ones.
module ss_scroll_ctrl #(
  parameter int unsigned MSG_DEPTH = 16,
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         WrEn,
  input  logic [$clog2(MSG_DEPTH)-1:0] WrAddr,
  input  logic [7:0]                   WrData,
  output logic                         WrReady,
  input  logic [$clog2(MSG_DEPTH):0]   MsgLen,
  input  logic                         Loop,
  input  logic                         Start,
  input  logic                         Stop,
  output logic                         Busy,
  output logic                         Done,
  output logic [7:0]                   C1,
  output logic [7:0]                   C2,
  output logic [7:0]                   C3,
  output logic [7:0]                   C4
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, STATIC, SCROLL} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [MSG_DEPTH];
  logic [LW-1:0] len, len_nxt, len_clamp;
  logic [LW-1:0] pos, pos_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          loop_mode, loop_nxt;
  logic          start_ok, tick, finish;
  logic          busy_nxt, done_nxt;
  logic [LW-1:0] win_idx [4];
  logic [7:0]    c_nxt   [4];

  assign WrReady = ~Busy;

  // Character buffer; frozen while a session is active, never cleared by reset
  always_ff @(posedge Clk) begin
    if (WrEn && !Busy) mem[WrAddr] <= WrData;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    len_clamp = (MsgLen > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : MsgLen;
    start_ok  = Start && (MsgLen != '0);
    tick      = (cnt == TW'(TICK_DIV - 1));
    finish    = tick && (pos == len) && !loop_mode;
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (len_clamp > LW'(4)) ? SCROLL : STATIC;
      STATIC:  if (Stop) state_nxt = IDLE;
      SCROLL:  if (Stop || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    len_nxt  = len;
    loop_nxt = loop_mode;
    pos_nxt  = pos;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          len_nxt  = len_clamp;
          loop_nxt = Loop;
          pos_nxt  = '0;
          cnt_nxt  = '0;
        end
      end
      STATIC: done_nxt = Stop;
      SCROLL: begin
        done_nxt = Stop || finish;
        // Stop wins over a coincident tick: no further step
        if (!Stop) begin
          cnt_nxt = tick ? '0 : cnt + TW'(1);
          if (tick) pos_nxt = (pos == len) ? '0 : pos + LW'(1);
        end
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != IDLE);
    for (int k = 0; k < 4; k++) begin
      win_idx[k] = pos_nxt + LW'(k);
      c_nxt[k]   = (busy_nxt && (win_idx[k] < len_nxt)) ? mem[win_idx[k][AW-1:0]] : BLANK;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      len       <= '0;
      loop_mode <= 1'b0;
      pos       <= '0;
      cnt       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      C1        <= BLANK;
      C2        <= BLANK;
      C3        <= BLANK;
      C4        <= BLANK;
    end else begin
      len       <= len_nxt;
      loop_mode <= loop_nxt;
      pos       <= pos_nxt;
      cnt       <= cnt_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      C1        <= c_nxt[0];
      C2        <= c_nxt[1];
      C3        <= c_nxt[2];
      C4        <= c_nxt[3];
    end
  end

endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// Directed bench for ss_scroll_ctrl with MSG_DEPTH=16, TICK_DIV=4.
module tb_ss_scroll_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TDIV  = 4;
  localparam logic [31:0] BLK4  = 32'h20202020;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       WrEn = 1'b0;
  logic [3:0] WrAddr = '0;
  logic [7:0] WrData = '0;
  logic       WrReady;
  logic [4:0] MsgLen = '0;
  logic       Loop = 1'b0;
  logic       Start = 1'b0;
  logic       Stop = 1'b0;
  logic       Busy, Done;
  logic [7:0] C1, C2, C3, C4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  len;
    logic        busy;
    logic [31:0] win;
  } svec_t;

  svec_t       stab [6];
  logic [31:0] swin [6];

  ss_scroll_ctrl #(.MSG_DEPTH(DEPTH), .TICK_DIV(TDIV), .BLANK(8'h20)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrReady(WrReady), .MsgLen(MsgLen), .Loop(Loop), .Start(Start), .Stop(Stop),
    .Busy(Busy), .Done(Done), .C1(C1), .C2(C2), .C3(C3), .C4(C4)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] win();
    return {C1, C2, C3, C4};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    step();
    WrEn = 1'b0;
  endtask

  task automatic start(input logic [4:0] l, input logic lp, input logic with_stop);
    Start = 1'b1; MsgLen = l; Loop = lp; Stop = with_stop;
    step();
    Start = 1'b0; Stop = 1'b0;
  endtask

  task automatic stop_and_check(input string name);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk({name, " done"}, Done, 1'b1);
    chk({name, " busy"}, Busy, 1'b0);
    chk({name, " blank"}, win(), BLK4);
    step();
    chk({name, " done drop"}, Done, 1'b0);
  endtask

  // Watchdog in case the run ever stalls
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stab[0] = '{5'd1,  1'b1, "H   "};
    stab[1] = '{5'd2,  1'b1, "HE  "};
    stab[2] = '{5'd3,  1'b1, "HEL "};
    stab[3] = '{5'd4,  1'b1, "HELL"};
    stab[4] = '{5'd0,  1'b0, "    "};
    stab[5] = '{5'd31, 1'b1, "HELL"};
    swin[0] = "HELL"; swin[1] = "ELLO"; swin[2] = "LLO ";
    swin[3] = "LO  "; swin[4] = "O   "; swin[5] = "    ";

    // Reset
    step(); step();
    Reset = 1'b0;
    chk("reset win", win(), BLK4);
    chk("reset busy", Busy, 1'b0);
    chk("reset done", Done, 1'b0);
    chk("reset wrready", WrReady, 1'b1);

    // Static "AB" held for 100 cycles, with a locked-out write in the middle
    wr(4'd0, "A");
    wr(4'd1, "B");
    start(5'd2, 1'b0, 1'b0);
    chk("static busy", Busy, 1'b1);
    chk("static wrready", WrReady, 1'b0);
    wr(4'd0, "Z");
    for (int i = 0; i < 100; i++) begin
      chk("static hold", win(), "AB  ");
      chk("static hold busy", Busy, 1'b1);
      step();
    end
    stop_and_check("static stop");
    chk("idle wrready", WrReady, 1'b1);

    // Start and Stop together in IDLE: session starts, buffer shows lockout held
    start(5'd2, 1'b0, 1'b1);
    chk("start+stop busy", Busy, 1'b1);
    chk("lockout readback", win(), "AB  ");
    stop_and_check("start+stop end");

    // Load "HELLO" and a known tail
    wr(4'd0, "H"); wr(4'd1, "E"); wr(4'd2, "L"); wr(4'd3, "L"); wr(4'd4, "O");
    for (int i = 5; i < 16; i++) wr(4'(i), 8'(8'h61 + i - 5));

    // Table: first window per length, then Stop (ignored in IDLE for L=0)
    for (int t = 0; t < 6; t++) begin
      start(stab[t].len, 1'b0, 1'b0);
      chk($sformatf("tab%0d busy", t), Busy, stab[t].busy);
      chk($sformatf("tab%0d win", t), win(), stab[t].win);
      chk($sformatf("tab%0d done", t), Done, 1'b0);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      chk($sformatf("tab%0d stop done", t), Done, stab[t].busy);
      chk($sformatf("tab%0d stop busy", t), Busy, 1'b0);
      step();
      chk($sformatf("tab%0d done drop", t), Done, 1'b0);
    end

    // Single scroll, with a Start during the session that must be ignored
    start(5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("scroll win%0d", i), win(), swin[i/4]);
      chk($sformatf("scroll busy%0d", i), Busy, 1'b1);
      chk($sformatf("scroll done%0d", i), Done, 1'b0);
      if (i == 9) begin Start = 1'b1; MsgLen = 5'd2; end
      step();
      Start = 1'b0;
    end
    chk("scroll end done", Done, 1'b1);
    chk("scroll end busy", Busy, 1'b0);
    chk("scroll end win", win(), BLK4);
    step();
    chk("scroll end done drop", Done, 1'b0);

    // Back-to-back: looped scroll, three laps, then Stop on a tick edge
    start(5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 76; i++) begin
      chk($sformatf("loop win%0d", i), win(), swin[(i/4)%6]);
      chk($sformatf("loop busy%0d", i), Busy, 1'b1);
      if (i == 75) Stop = 1'b1;
      step();
    end
    Stop = 1'b0;
    chk("loop stop done", Done, 1'b1);
    chk("loop stop busy", Busy, 1'b0);
    chk("loop stop win", win(), BLK4);
    step();
    chk("loop stop done drop", Done, 1'b0);
    chk("loop stop no step", win(), BLK4);

    // L=31 clamps to 16: done after 17 windows
    start(5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 68; i++) begin
      chk($sformatf("clamp busy%0d", i), Busy, 1'b1);
      if (i == 0) chk("clamp first", win(), "HELL");
      if (i >= 60 && i < 64) chk($sformatf("clamp pos15 %0d", i), win(), 32'h6b202020);
      if (i >= 64) chk($sformatf("clamp pos16 %0d", i), win(), BLK4);
      step();
    end
    chk("clamp done", Done, 1'b1);
    chk("clamp busy end", Busy, 1'b0);
    step();

    // Mid-session reset, then immediate replay
    start(5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("pre-reset win", win(), "ELLO");
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midreset busy", Busy, 1'b0);
    chk("midreset done", Done, 1'b0);
    chk("midreset win", win(), BLK4);
    chk("midreset wrready", WrReady, 1'b1);
    start(5'd5, 1'b0, 1'b0);
    chk("replay done", Done, 1'b0);
    chk("replay win0", win(), "HELL");
    for (int i = 0; i < 4; i++) step();
    chk("replay win1", win(), "ELLO");
    stop_and_check("replay stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
